// File: rtl/trap_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : trap_pkg
// Description : Shared types and constants for the machine-mode trap
//               sequencer: FSM state encoding, interrupt cause codes,
//               mstatus bit positions and CSR addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        SAVE  = 3'd2,
        JUMP  = 3'd3,
        MRET  = 3'd4
    } trap_state_e;

    // Interrupt exception codes (mcause[3:0])
    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    // mstatus bit positions
    localparam int MIE    = 3;
    localparam int MPIE   = 7;
    localparam int MPP_LO = 11;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Highest-priority enabled source: external beats timer
    function automatic logic [3:0] irq_code(input logic ext_en, input logic tmr_en);
        logic [3:0] code;
        code = CAUSE_MTI;
        if (ext_en) begin
            code = CAUSE_MEI;
        end else if (tmr_en) begin
            code = CAUSE_MTI;
        end
        return code;
    endfunction

endpackage : trap_pkg
`default_nettype wire

// File: rtl/irq_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : irq_sync
// Description : Parameterised-width two-flop synchroniser for asynchronous
//               level interrupt requests. Clears to 0 on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; the first stage may go metastable, the second is clean
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : irq_sync
`default_nettype wire

// File: rtl/trap_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode interrupt/trap sequencer. Samples pending
//               interrupts against mstatus/mie, drains the pipeline, emits
//               the hardware CSR writes (mepc, mcause, mstatus) and redirects
//               fetch to mtvec. Also executes mret.
// Config      : TRAP_IRQ_SYNC_EN - when defined, ext/tmr requests pass
//               through a 2-flop synchroniser (2 cycles extra latency).
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    input  logic            mret_i,
    input  logic            ext_irq_i,
    input  logic            tmr_irq_i,
    input  logic [XLEN-1:0] csr_mstatus_i,
    input  logic [XLEN-1:0] csr_mie_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    output logic [XLEN-1:0] mip_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic            hw_wr_en_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mstatus_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o
);

    import trap_pkg::*;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    trap_state_e     state_q, state_d;
    logic [3:0]      cnt_q,   cnt_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [3:0]      code_q,  code_d;

    logic [1:0]      irq_src;      // {ext, tmr} as seen by the sequencer
    logic [XLEN-1:0] pending;
    logic            take;
    logic [3:0]      take_code;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] tvec_off;

`ifdef TRAP_IRQ_SYNC_EN
    irq_sync #(
        .WIDTH (2)
    ) u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   ({ext_irq_i, tmr_irq_i}),
        .q_o   (irq_src)
    );
`else
    assign irq_src = {ext_irq_i, tmr_irq_i};
`endif

    // Live pending bits; held at 0 while reset is asserted
    always_comb begin
        mip_o = '0;
        if (reset) begin
            mip_o[11] = irq_src[1];
            mip_o[7]  = irq_src[0];
        end
    end

    assign pending   = mip_o & csr_mie_i;
    assign take      = csr_mstatus_i[MIE] & (|pending);
    assign take_code = irq_code(pending[11], pending[7]);

    assign tvec_base = {csr_mtvec_i[XLEN-1:2], 2'b00};
    assign tvec_off  = {{(XLEN-6){1'b0}}, code_q, 2'b00};

    // State, drain counter and captured trap context
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            code_q  <= code_d;
        end
    end

    // Next-state: mret wins over a simultaneous interrupt; context is
    // captured on entry so a dropped source cannot abort the sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (mret_i) begin
                    state_d = MRET;
                end else if (take) begin
                    state_d = DRAIN;
                    pc_d    = pc_i;
                    code_d  = take_code;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = SAVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAVE:    state_d = JUMP;
            JUMP:    state_d = IDLE;
            MRET:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        stall_o       = 1'b0;
        flush_o       = 1'b0;
        hw_wr_en_o    = 1'b0;
        mepc_o        = '0;
        mcause_o      = '0;
        mstatus_o     = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        busy_o        = (state_q != IDLE);
        case (state_q)
            DRAIN: begin
                stall_o = 1'b1;
            end
            SAVE: begin
                stall_o    = 1'b1;
                flush_o    = 1'b1;
                hw_wr_en_o = 1'b1;
                mepc_o     = {pc_q[XLEN-1:2], 2'b00};
                mcause_o   = {1'b1, {(XLEN-5){1'b0}}, code_q};
                mstatus_o                    = csr_mstatus_i;
                mstatus_o[MPIE]              = csr_mstatus_i[MIE];
                mstatus_o[MIE]               = 1'b0;
                mstatus_o[MPP_LO+1:MPP_LO]   = 2'b11;
            end
            JUMP: begin
                flush_o       = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = (csr_mtvec_i[1:0] == 2'b01) ? (tvec_base + tvec_off)
                                                            : tvec_base;
            end
            MRET: begin
                flush_o         = 1'b1;
                hw_wr_en_o      = 1'b1;
                redirect_o      = 1'b1;
                mepc_o          = csr_mepc_i;
                mstatus_o       = csr_mstatus_i;
                mstatus_o[MIE]  = csr_mstatus_i[MPIE];
                mstatus_o[MPIE] = 1'b1;
                redirect_pc_o   = csr_mepc_i;
            end
            default: ;
        endcase
    end

endmodule : trap_ctrl
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Scoreboard bench for trap_ctrl. Expected CSR-write and
//               redirect strobes are queued when stimulus is applied and
//               checked when the DUT emits them. A tiny CSR-file model
//               writes back mstatus/mepc on each hardware write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

    localparam int DRAIN = 2;
`ifdef TRAP_IRQ_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    typedef struct {
        logic        wr;
        logic        rd;
        logic        stl;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mst;
        logic [31:0] rpc;
        int          cyc;
    } ev_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc_i;
    logic        mret_i;
    logic        ext_irq_i;
    logic        tmr_irq_i;
    logic [31:0] csr_mstatus;
    logic [31:0] csr_mie;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic [31:0] mip_o;
    logic        stall_o;
    logic        flush_o;
    logic        hw_wr_en_o;
    logic [31:0] mepc_o;
    logic [31:0] mcause_o;
    logic [31:0] mstatus_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    ev_t sb[$];
    ev_t mon_e;
    int  cyc    = 0;
    int  n_cmp  = 0;
    int  n_bad  = 0;

    trap_ctrl #(
        .DRAIN_CYCLES (DRAIN),
        .XLEN         (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_i          (pc_i),
        .mret_i        (mret_i),
        .ext_irq_i     (ext_irq_i),
        .tmr_irq_i     (tmr_irq_i),
        .csr_mstatus_i (csr_mstatus),
        .csr_mie_i     (csr_mie),
        .csr_mtvec_i   (csr_mtvec),
        .csr_mepc_i    (csr_mepc),
        .mip_o         (mip_o),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .hw_wr_en_o    (hw_wr_en_o),
        .mepc_o        (mepc_o),
        .mcause_o      (mcause_o),
        .mstatus_o     (mstatus_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic wr, input logic rd, input logic stl,
                           input logic [31:0] mepc, input logic [31:0] mcause,
                           input logic [31:0] mst, input logic [31:0] rpc, input int c);
        ev_t e;
        e.wr = wr; e.rd = rd; e.stl = stl;
        e.mepc = mepc; e.mcause = mcause; e.mst = mst; e.rpc = rpc; e.cyc = c;
        sb.push_back(e);
    endtask

    // Reference mstatus transforms
    function automatic logic [31:0] trap_mst(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[7] = m[3];
        r[3] = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_mst(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[3] = m[7];
        r[7] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] tvec_tgt(input logic [31:0] tv, input logic [3:0] code);
        logic [31:0] base;
        base = tv & 32'hFFFF_FFFC;
        return (tv[1:0] == 2'b01) ? base + {26'd0, code, 2'b00} : base;
    endfunction

    // Output monitor: every strobe must match the head of the scoreboard;
    // write strobes also update the modelled CSR file
    always @(negedge clk) begin
        if (reset && (hw_wr_en_o || redirect_o)) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {31'd0, 1'b1}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_cycle", cyc, mon_e.cyc);
                chk("hw_wr_en", {31'd0, hw_wr_en_o}, {31'd0, mon_e.wr});
                chk("redirect", {31'd0, redirect_o}, {31'd0, mon_e.rd});
                chk("stall", {31'd0, stall_o}, {31'd0, mon_e.stl});
                chk("flush", {31'd0, flush_o}, 32'd1);
                if (mon_e.wr) begin
                    chk("mepc", mepc_o, mon_e.mepc);
                    chk("mcause", mcause_o, mon_e.mcause);
                    chk("mstatus", mstatus_o, mon_e.mst);
                end else begin
                    chk("jump_mcause_zero", mcause_o, 32'd0);
                end
                if (mon_e.rd) begin
                    chk("redirect_pc", redirect_pc_o, mon_e.rpc);
                end
            end
            if (hw_wr_en_o) begin
                csr_mstatus = mstatus_o;
                csr_mepc    = mepc_o;
            end
        end
    end

    task automatic wait_sb();
        for (int i = 0; i < 60 && sb.size() != 0; i++) step(1);
        chk("scoreboard_drained", sb.size(), 32'd0);
    endtask

    task automatic idle_clean();
        ext_irq_i   = 1'b0;
        tmr_irq_i   = 1'b0;
        csr_mstatus = 32'h0;
        mret_i      = 1'b0;
        step(SL + 3);
    endtask

    task automatic run_trap(input logic [31:0] pc, input logic [31:0] mst,
                            input logic [31:0] mie, input logic [31:0] tv,
                            input logic ext, input logic tmr, input logic [3:0] code,
                            input logic [31:0] exp_mip);
        int n;
        pc_i = pc; csr_mstatus = mst; csr_mie = mie; csr_mtvec = tv;
        ext_irq_i = ext; tmr_irq_i = tmr;
        n = cyc;
        push_ev(1'b1, 1'b0, 1'b1, pc & 32'hFFFF_FFFC, 32'h8000_0000 | {28'd0, code},
                trap_mst(mst), 32'd0, n + SL + DRAIN + 1);
        push_ev(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, tvec_tgt(tv, code),
                n + SL + DRAIN + 2);
        step(SL + 1);
        chk("drain_busy", {31'd0, busy_o}, 32'd1);
        chk("drain_stall", {31'd0, stall_o}, 32'd1);
        chk("mip", mip_o, exp_mip);
        wait_sb();
        step(3);
        chk("no_reentry_busy", {31'd0, busy_o}, 32'd0);
        idle_clean();
    endtask

    task automatic run_mret(input logic [31:0] mst, input logic [31:0] mepc,
                            input logic with_irq, input logic [31:0] pc);
        int n;
        csr_mtvec = 32'h0000_0300;
        if (with_irq) begin
            csr_mie = 32'h800; ext_irq_i = 1'b1; pc_i = pc;
            step(SL + 1);
        end
        csr_mstatus = mst; csr_mepc = mepc; mret_i = 1'b1;
        n = cyc;
        push_ev(1'b1, 1'b1, 1'b0, mepc, 32'd0, mret_mst(mst), mepc, n + 1);
        if (with_irq) begin
            push_ev(1'b1, 1'b0, 1'b1, pc & 32'hFFFF_FFFC, 32'h8000_000B,
                    trap_mst(mret_mst(mst)), 32'd0, n + 2 + DRAIN + 1);
            push_ev(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'h0000_0300,
                    n + 2 + DRAIN + 2);
        end
        step(1);
        mret_i = 1'b0;
        if (with_irq) begin
            step(2);
            chk("mret_then_drain", {31'd0, busy_o}, 32'd1);
        end
        wait_sb();
        idle_clean();
    endtask

    logic sticky;

    initial begin
        reset = 1'b0; pc_i = '0; mret_i = 1'b0; ext_irq_i = 1'b0; tmr_irq_i = 1'b0;
        csr_mstatus = '0; csr_mie = '0; csr_mtvec = '0; csr_mepc = '0;
        step(2);
        ext_irq_i = 1'b1;
        step(1);
        // Reset state
        chk("rst_mip", mip_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_wr", {31'd0, hw_wr_en_o}, 32'd0);
        chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
        chk("rst_rpc", redirect_pc_o, 32'd0);
        chk("rst_mstatus", mstatus_o, 32'd0);
        ext_irq_i = 1'b0;
        reset = 1'b1;
        step(2);

        // Basic external trap, direct mode
        run_trap(32'h40, 32'h8, 32'h800, 32'h100, 1'b1, 1'b0, 4'd11, 32'h800);
        // Vectored mode, unaligned pc
        run_trap(32'h47, 32'h8, 32'h800, 32'h101, 1'b1, 1'b0, 4'd11, 32'h800);
        // Both pending, both enabled: external wins
        run_trap(32'h1000, 32'h8, 32'h880, 32'h200, 1'b1, 1'b1, 4'd11, 32'h880);
        // Both pending, only timer enabled; other mstatus bits pass through
        run_trap(32'h2004, 32'hFFFF_FF7F, 32'h080, 32'h201, 1'b1, 1'b1, 4'd7, 32'h880);

        // Globally disabled, then source masked by mie: no activity
        csr_mstatus = 32'h0; csr_mie = 32'h800; ext_irq_i = 1'b1;
        sticky = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            sticky = sticky | busy_o | hw_wr_en_o | redirect_o | stall_o;
        end
        chk("mie_off_quiet", {31'd0, sticky}, 32'd0);
        chk("mie_off_mip", mip_o, 32'h800);
        csr_mstatus = 32'h8; csr_mie = 32'h080;
        sticky = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            sticky = sticky | busy_o | hw_wr_en_o | redirect_o;
        end
        chk("masked_src_quiet", {31'd0, sticky}, 32'd0);
        idle_clean();

        // mret together with a takeable interrupt: mret first, then trap
        run_mret(32'h1888, 32'h44, 1'b1, 32'h60);
        // mret restoring MIE=0 from MPIE=0
        run_mret(32'h0008, 32'h80, 1'b0, 32'h0);

        // Reset in the middle of DRAIN
        csr_mstatus = 32'h8; csr_mie = 32'h800; csr_mtvec = 32'h100;
        pc_i = 32'h90; ext_irq_i = 1'b1;
        step(SL + 1);
        chk("pre_reset_busy", {31'd0, busy_o}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, busy_o}, 32'd0);
        chk("async_reset_stall", {31'd0, stall_o}, 32'd0);
        chk("async_reset_mip", mip_o, 32'd0);
        ext_irq_i = 1'b0; csr_mstatus = 32'h0;
        step(2);
        reset = 1'b1;
        sticky = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            sticky = sticky | busy_o | redirect_o | hw_wr_en_o;
        end
        chk("post_reset_quiet", {31'd0, sticky}, 32'd0);
        chk("final_scoreboard", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_trap_ctrl
`default_nettype wire

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode interrupt/trap sequencer placed between the core pipeline and the CSR register file. It samples pending interrupt sources against mstatus/mie, drains the pipeline, and generates the hardware CSR writes (mepc, mcause, mstatus). It then redirects fetch to the mtvec target. It also executes mret by restoring mstatus and redirecting to mepc.

Parameters:
DRAIN_CYCLES, 2, stall cycles before SAVE so in-flight instructions retire (legal range 1..15)
XLEN, 32, data/address width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
pc_i  input  XLEN  PC of the oldest uncommitted instruction
mret_i  input  1  mret decoded in execute stage, single-cycle pulse
ext_irq_i  input  1  external interrupt request, level, asynchronous
tmr_irq_i  input  1  timer interrupt request, level, asynchronous
csr_mstatus_i  input  XLEN  current mstatus
csr_mie_i  input  XLEN  current mie
csr_mtvec_i  input  XLEN  current mtvec
csr_mepc_i  input  XLEN  current mepc
mip_o  output  XLEN  live pending bits: bit11 = ext, bit7 = tmr, others 0
stall_o  output  1  freeze fetch/decode
flush_o  output  1  kill in-flight instructions
hw_wr_en_o  output  1  one-cycle strobe: CSR file loads the three values below
mepc_o  output  XLEN  value for mepc
mcause_o  output  XLEN  value for mcause
mstatus_o  output  XLEN  value for mstatus
redirect_o  output  1  one-cycle PC redirect strobe
redirect_pc_o  output  XLEN  redirect target
busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset (reset low, async): state IDLE; drain counter 0; captured PC and cause 0; all outputs 0 except mip_o, which shows the synchronised sources (0 during reset).
- take = csr_mstatus_i[3] & |(mip_o & csr_mie_i). Priority: ext (cause 11) over tmr (cause 7).
- mcause_o = {1'b1, 27'b0, code[3:0]}.
- States: IDLE, DRAIN, SAVE, JUMP, MRET.
- IDLE: mret_i -> MRET (mret wins over a simultaneous take). Otherwise take -> DRAIN; capture pc_i and cause code in the same cycle; load counter = DRAIN_CYCLES-1.
- DRAIN: stall_o=1. Counter decrements each cycle; at 0 -> SAVE. Source deassertion after capture does not abort.
- SAVE: stall_o=1, flush_o=1, hw_wr_en_o=1 for exactly one cycle.
  - mepc_o = captured PC with bits[1:0] forced 0.
  - mstatus_o = csr_mstatus_i with MPIE[7] set to old MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
  - Next state JUMP.
- JUMP: redirect_o=1, flush_o=1. Target: base = {mtvec[31:2],2'b00}; if mtvec[1:0]==2'b01, redirect_pc_o = base + (code<<2), else redirect_pc_o = base. Arithmetic is modulo 2^XLEN, wrap ignored. Next state IDLE.
- MRET: one cycle with hw_wr_en_o=1, flush_o=1, redirect_o=1.
  - mstatus_o: MIE = old MPIE, MPIE = 1, MPP unchanged.
  - mepc_o = csr_mepc_i (rewrite unchanged); mcause_o = csr_mcause passthrough not required, so drive 0 and the CSR file ignores mcause on the mret strobe (mret_i qualifies).
  - redirect_pc_o = csr_mepc_i. Next state IDLE.
- Trap latency: take sampled in IDLE to redirect_o = DRAIN_CYCLES+2 cycles.
- Back-to-back: in the IDLE cycle after JUMP, take is re-evaluated. MIE is now 0, so no re-entry until software or mret re-enables it.
- mret_i outside IDLE is ignored; the pipeline is stalled/flushed, so none should occur.
- Reset mid-sequence: returns to IDLE immediately and no partial CSR write occurs. hw_wr_en_o is asserted only in SAVE/MRET.
- Outputs not named above are 0 in each state (Moore, decoded from registered state).

Optional Feature:
TRAP_IRQ_SYNC_EN
- Defined: ext_irq_i and tmr_irq_i each pass through a 2-flop synchroniser (reset to 0) before mip_o. Adds 2 cycles of input latency.
- Undefined: inputs drive mip_o directly and must be synchronous to clk.

Decomposition:
- Package trap_pkg:
  - state enum trap_state_e {IDLE, DRAIN, SAVE, JUMP, MRET}
  - cause constants CAUSE_MEI=11, CAUSE_MTI=7
  - mstatus bit indices MIE=3, MPIE=7, MPP_LO=11
  - CSR address constants (300, 304, 305, 341, 342, 344 hex)
- Sub-module: irq_sync (parameterised-width 2-flop synchroniser, async active-low reset), instantiated only under TRAP_IRQ_SYNC_EN.

Test Plan:
- Reset low mid-DRAIN, then release -> busy_o=0, hw_wr_en_o never pulsed, redirect_o=0.
- mstatus=0x8, mie=0x800, mtvec=0x100, pc_i=0x40, ext_irq 1 -> after DRAIN_CYCLES+1 cycles one SAVE cycle: mepc_o=0x40, mcause_o=0x8000000B, mstatus_o=0x1880; next cycle redirect_pc_o=0x100.
- Same, but mtvec=0x101 -> redirect_pc_o=0x12C.
- ext and tmr both pending, mie=0x880 -> mcause_o=0x8000000B; with mie=0x080 -> 0x80000007, vectored target base+0x1C.
- mstatus=0x0 (MIE=0), irq pending for 20 cycles -> busy_o stays 0, no strobes.
- mret_i with take true in the same cycle, mstatus=0x1880, mepc=0x44 -> MRET: mstatus_o=0x1888, redirect_pc_o=0x44; the next IDLE cycle enters DRAIN.
